gc_conf_feeder: RTL

GC_CONF_FEEDER -- requirements
Module: gc_conf_feeder

---
 rtl/gc_conf_feeder_pkg.sv | 17 +
 rtl/gc_conf_ram.sv | 25 ++
 rtl/gc_conf_feeder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gc_conf_feeder_pkg.sv
// Shared global-controller definitions: configuration-feeder state encoding and default
// conf_bus width/depth constants.
package gc_conf_feeder_pkg;

  localparam int unsigned GcConfWidth     = 16;
  localparam int unsigned GcConfDepth     = 64;
  localparam int unsigned GcConfAddrWidth = 6;

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StStream,
    StDone,
    StError
  } conf_state_e;

endpackage

// File: rtl/gc_conf_ram.sv
// Configuration word store: single synchronous write port, asynchronous read, no reset.
module gc_conf_ram #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gc_conf_feeder.sv
// Buffers a host-written configuration image and streams it word by word to the global
// controller's loader, with stall, completion and underrun handling.
module gc_conf_feeder
  import gc_conf_feeder_pkg::*;
#(
  parameter int unsigned ITERATION_VARIABLE_WIDTH = GcConfWidth,
  parameter int unsigned DEPTH                    = GcConfDepth,
  parameter int unsigned ADDR_WIDTH               = GcConfAddrWidth
) (
  input  logic                                conf_clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] wr_data,
  input  logic                                wr_last,
  input  logic                                clear,
  input  logic                                conf_en,
  input  logic                                config_busy,
  input  logic                                config_done,
  output logic [ITERATION_VARIABLE_WIDTH-1:0] conf_bus,
  output logic                                pdone,
  output logic                                underrun,
  output logic [ADDR_WIDTH:0]                 words_sent
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;

  conf_state_e state_q, state_d;
  logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] word_count_q, word_count_d;
  logic [CntW-1:0] words_sent_q, words_sent_d;
  logic            underrun_q, underrun_d;

  logic                                ram_we;
  logic [ITERATION_VARIABLE_WIDTH-1:0] ram_rdata;
  logic                                consume_req;

  gc_conf_ram #(
    .WIDTH      (ITERATION_VARIABLE_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (conf_clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  assign consume_req = conf_en & ~config_busy & ~config_done;

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    word_count_d = word_count_q;
    words_sent_d = words_sent_q;
    underrun_d   = underrun_q;
    ram_we       = 1'b0;

    if (clear) begin
      // Re-arm only; a write in the same cycle is dropped and memory is kept.
      state_d      = StIdle;
      rd_ptr_d     = '0;
      word_count_d = '0;
      words_sent_d = '0;
      underrun_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wr_en) begin
            ram_we = 1'b1;
            if (wr_last) begin
              word_count_d = CntW'(wr_addr) + CntW'(1);
              state_d      = StReady;
            end
          end
        end
        StReady: begin
          if (conf_en) begin
            state_d = StStream;
          end
        end
        StStream: begin
          if (config_done) begin
            state_d = StDone;
          end else if (consume_req) begin
            if (rd_ptr_q < word_count_q) begin
              rd_ptr_d     = rd_ptr_q + CntW'(1);
              words_sent_d = words_sent_q + CntW'(1);
            end else begin
              state_d    = StError;
              underrun_d = 1'b1;
            end
          end
        end
        StDone, StError: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge conf_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rd_ptr_q     <= '0;
      word_count_q <= '0;
      words_sent_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      word_count_q <= word_count_d;
      words_sent_q <= words_sent_d;
      underrun_q   <= underrun_d;
    end
  end

  // Past the last word (rd_ptr == DEPTH) drive zero rather than alias onto mem[0].
  always_comb begin
    conf_bus = '0;
    if ((state_q == StReady || state_q == StStream || state_q == StDone) &&
        !rd_ptr_q[ADDR_WIDTH]) begin
      conf_bus = ram_rdata;
    end
  end

  assign pdone      = (state_q != StIdle);
  assign underrun   = underrun_q;
  assign words_sent = words_sent_q;

endmodule
